// File: rtl/progress_monitor_pkg.sv
// -----------------------------------------------------------------------------
// progress_monitor_pkg
// Shared types and default constants for the progress monitor.
//   mon_state_e   : 3-bit monitor state encoding (IDLE=0 .. DONE=4)
//   DEF_*         : default thresholds, counter width and pass code
// -----------------------------------------------------------------------------
package progress_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_WARN = 3'd2,
      ST_HUNG = 3'd3,
      ST_DONE = 3'd4
   } mon_state_e;

   localparam int unsigned DEF_STALL_WARN  = 1000;
   localparam int unsigned DEF_STALL_LIMIT = 10000;
   localparam int unsigned DEF_CNT_W       = 32;
   localparam logic [7:0]  DEF_PASS_CODE   = 8'h5A;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at MAX, with synchronous clear and hold.
// Priority on each edge: hold > clr > inc.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (count -> 0)
//   clr    : load zero
//   inc    : add one unless already at MAX
//   hold   : freeze the count (overrides clr and inc)
//   count  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr,
   input  logic             inc,
   input  logic             hold,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count;
      if (hold) begin
         count_d = count;
      end else if (clr) begin
         count_d = '0;
      end else if (inc && (count != MAX)) begin
         count_d = count + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/progress_monitor.sv
// -----------------------------------------------------------------------------
// progress_monitor
// Liveness monitor for one valid/ready channel plus a DUT busy flag. Counts
// consecutive stall cycles, pulses a warning, then declares a hang; or ends
// the run on a done strobe with a pass/fail verdict.
//
// Channel semantics: a transfer (hs) happens on any cycle where valid_i and
// ready_i are both high. A stall is a cycle where busy_i is high and no
// transfer happens. valid_i may rise without ready_i and vice versa; the
// monitor only observes, it never back-pressures.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   enable_i        : monitoring enable (IDLE <-> RUN)
//   valid_i/ready_i : monitored handshake
//   busy_i          : DUT has outstanding work
//   done_i          : end-of-test strobe, done_code_i sampled with it
//   state_o         : current state (mon_state_e encoding)
//   stall_cnt_o     : consecutive stall count, saturates at STALL_LIMIT
//   xfer_cnt_o      : handshakes seen, saturates at all-ones
//   warn_o          : one-cycle pulse on entering WARN
//   hang_o          : high while HUNG
//   pass_o/fail_o   : DONE verdict levels
//   end_o           : one-cycle pulse on entering HUNG or DONE
// All outputs are registered: one cycle of latency from the causing input.
// -----------------------------------------------------------------------------
module progress_monitor
   import progress_monitor_pkg::*;
#(
   parameter int unsigned STALL_WARN  = DEF_STALL_WARN,
   parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter logic [7:0]  PASS_CODE   = DEF_PASS_CODE
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             valid_i,
   input  logic             ready_i,
   input  logic             busy_i,
   input  logic             done_i,
   input  logic [7:0]       done_code_i,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] xfer_cnt_o,
   output logic             warn_o,
   output logic             hang_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             end_o
);

   localparam logic [CNT_W-1:0] WARN_CNT  = CNT_W'(STALL_WARN);
   localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STALL_LIMIT);

   mon_state_e       state_q, state_d;
   logic             warn_q, warn_d;
   logic             end_q, end_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;

   logic             hs, stall, active;
   logic [CNT_W-1:0] stall_cnt, xfer_cnt;
   logic [CNT_W-1:0] stall_nxt;

   assign hs     = valid_i & ready_i;
   assign stall  = busy_i & ~hs;
   assign active = (state_q == ST_RUN) || (state_q == ST_WARN);

   // Counters only move while actively monitoring; a done strobe freezes
   // them on the same edge the state goes terminal.
   sat_counter #(
      .WIDTH (CNT_W),
      .MAX   (LIMIT_CNT)
   ) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (~enable_i | ~stall),
      .inc    (stall),
      .hold   (~active | done_i),
      .count  (stall_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_W),
      .MAX   ({CNT_W{1'b1}})
   ) u_xfer_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (1'b0),
      .inc    (hs),
      .hold   (~active | done_i | ~enable_i),
      .count  (xfer_cnt)
   );

   // Value the stall counter loads on this edge when active, enabled and not
   // done; the FSM thresholds look at it so state and count move together.
   always_comb begin
      stall_nxt = '0;
      if (stall) begin
         stall_nxt = (stall_cnt == LIMIT_CNT) ? LIMIT_CNT : stall_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      warn_d  = 1'b0;
      end_d   = 1'b0;
      pass_d  = pass_q;
      fail_d  = fail_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_i) state_d = ST_RUN;
         end
         ST_RUN, ST_WARN: begin
            if (done_i) begin
               state_d = ST_DONE;
               end_d   = 1'b1;
               pass_d  = (done_code_i == PASS_CODE);
               fail_d  = (done_code_i != PASS_CODE);
            end else if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (stall_nxt == LIMIT_CNT) begin
               state_d = ST_HUNG;
               end_d   = 1'b1;
            end else if ((state_q == ST_RUN) && (stall_nxt == WARN_CNT)) begin
               state_d = ST_WARN;
               warn_d  = 1'b1;
            end else if ((state_q == ST_WARN) && !stall) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            // HUNG and DONE are terminal until reset.
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         warn_q  <= 1'b0;
         end_q   <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         warn_q  <= warn_d;
         end_q   <= end_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt;
   assign xfer_cnt_o  = xfer_cnt;
   assign warn_o      = warn_q;
   assign hang_o      = (state_q == ST_HUNG);
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign end_o       = end_q;

endmodule

// File: doc/progress_monitor.md
Name: progress_monitor

Overview:
- Synthesizable liveness monitor that feeds the simulation watchdog stage.
- Watches one valid/ready channel plus a DUT busy flag and counts consecutive stall cycles.
- Raises a warning, then a hang indication, or reports end-of-test pass/fail from a done/code strobe.
- Its end_o/hang_o outputs let the watchdog terminate a run early instead of waiting for the global cycle budget.

Parameters:
STALL_WARN, 1000, consecutive stall cycles before warn_o pulses (must be >0 and <STALL_LIMIT)
STALL_LIMIT, 10000, consecutive stall cycles before HUNG (must be <2**CNT_W)
CNT_W, 32, width of stall and transfer counters
PASS_CODE, 8'h5A, done_code_i value meaning pass

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
enable_i  input  1  monitoring enable
valid_i  input  1  monitored channel valid
ready_i  input  1  monitored channel ready
busy_i  input  1  DUT reports outstanding work
done_i  input  1  end-of-test strobe
done_code_i  input  8  end-of-test result code, sampled with done_i
state_o  output  3  current state encoding
stall_cnt_o  output  CNT_W  current consecutive stall count
xfer_cnt_o  output  CNT_W  handshakes seen, saturating at all-ones
warn_o  output  1  one-cycle pulse on entering WARN
hang_o  output  1  level, high in HUNG
pass_o  output  1  level, DONE with code==PASS_CODE
fail_o  output  1  level, DONE with code!=PASS_CODE
end_o  output  1  one-cycle pulse on entering HUNG or DONE

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all counters 0; all outputs 0.
- Definitions: hs = valid_i & ready_i. stall = busy_i & ~hs.
- States: IDLE, RUN, WARN, HUNG, DONE.
- All state and counter updates occur on the same clock edge. Outputs are registered, with one cycle of latency from the causing input.
- IDLE: counters hold. enable_i=1 -> RUN.
- RUN/WARN, evaluated in priority order:
  1. done_i=1 -> DONE. Latch pass or fail from done_code_i. done_i wins over every other condition in the same cycle.
  2. enable_i=0 -> IDLE. stall_cnt clears; xfer_cnt holds.
  3. stall_cnt next value:
     - 0 on hs or ~busy_i.
     - +1 on stall.
     - Saturates at STALL_LIMIT.
  4. xfer_cnt +1 on hs, saturating at all-ones.
  5. stall_cnt next == STALL_LIMIT -> HUNG.
  6. RUN with stall_cnt next == STALL_WARN -> WARN.
  7. WARN with hs or ~busy_i -> RUN.
- Timing consequence: after exactly STALL_WARN consecutive stall cycles, state_o==WARN and warn_o=1 on the following cycle. warn_o is high for that cycle only.
- WARN re-entry: re-entering RUN and stalling STALL_WARN cycles again produces a fresh warn_o pulse.
- HUNG, DONE: terminal until reset. All inputs are ignored. Counters freeze.
- end_o is high for exactly the first cycle in HUNG or DONE.
- valid_i/ready_i/busy_i are don't-care while in IDLE, HUNG or DONE.
- Reset mid-operation returns to IDLE immediately, with no end_o pulse.

Decomposition:
- Shared package (progress_monitor_pkg):
  - mon_state_e enum: IDLE=0, RUN=1, WARN=2, HUNG=3, DONE=4; 3-bit.
  - Default STALL_WARN/STALL_LIMIT/PASS_CODE constants.
- Sub-module sat_counter: parameter WIDTH and MAX; inputs clr, inc, hold; output count. Instantiated twice:
  - stall counter with MAX=STALL_LIMIT.
  - transfer counter with MAX=all-ones.
- FSM and output registers live in the top module.

Test Plan:
- All scenarios use STALL_WARN=4, STALL_LIMIT=8, PASS_CODE=8'h5A.
- Reset, enable_i=1, busy_i=1, no hs for 8 cycles -> warn_o pulses the cycle after the 4th stall. State enters HUNG the cycle after the 8th stall. hang_o=1, end_o pulses once, stall_cnt_o=8.
- Stall 3 cycles, one hs, stall 3 cycles -> warn_o never asserted; xfer_cnt_o=1; stall_cnt_o=3.
- RUN, then done_i=1 with done_code_i=8'h5A -> next cycle: state DONE, pass_o=1, fail_o=0, end_o one-cycle pulse. Repeat with code 8'h00 -> fail_o=1.
- Stall 7 cycles, then 8th stall cycle with done_i=1 code 8'h5A -> DONE, pass_o=1, hang_o stays 0.
- Reach WARN (4 stalls), then drop rst_ni mid-cycle -> all outputs 0 immediately (asynchronous). After release, state_o=IDLE until enable_i=1.
- Stall 3 cycles, busy_i=0 for 1 cycle, stall 3 cycles, enable_i=0 -> no warn_o; stall_cnt_o returns to 0; state IDLE; xfer_cnt_o unchanged.
